read_bpm_test_link: RTL

READ_BPM_TEST_LINK -- requirements
Module: read_bpm_test_link

---
 rtl/read_bpm_test_link.sv | 117 +++++++++++
 1 files changed

// File: rtl/read_bpm_test_link.sv
// read_bpm_test_link: checks per-session BPM test packets on an AXI stream and reports a verdict per FA strobe
module read_bpm_test_link (
  input  logic        auroraUserClk,
  input  logic        auroraReset,
  input  logic        auroraFAstrobe,
  input  logic [5:0]  expectedBPMcount,
  input  logic [31:0] BPM_TEST_AXI_STREAM_RX_tdata,
  input  logic        BPM_TEST_AXI_STREAM_RX_tvalid,
  input  logic        BPM_TEST_AXI_STREAM_RX_tlast,
  output logic        BPM_TEST_AXI_STREAM_RX_tready,
  output logic        TESTstatusStrobe,
  output logic [1:0]  TESTstatusCode,
  output logic [5:0]  sessionPacketCount,
  output logic [15:0] errorCount,
  output logic [14:0] lastFAcycle
);
  typedef enum logic [2:0] {HEADER, X, Y, SUM, DISCARD} state_t;
  state_t st_q, st_d, st_b;
  logic [5:0] k_q, k_d, k_b, spc_q, spc_d;
  logic cf_q, cf_d, ff_q, ff_d, open_q, open_d, pv_q, pv_d, strobe_q, strobe_d;
  logic [14:0] fa_q, fa_d, pfa_q, pfa_d, lfa_q, lfa_d, w_fa;
  logic [1:0] code_q, code_d, verdict_code;
  logic [15:0] err_q, err_d;
  logic [31:0] w;
  logic tl, acc, verdict;
  assign w = BPM_TEST_AXI_STREAM_RX_tdata;
  assign w_fa = w[30:16];
  assign tl = BPM_TEST_AXI_STREAM_RX_tlast;
  assign BPM_TEST_AXI_STREAM_RX_tready = !auroraReset;
  assign acc = BPM_TEST_AXI_STREAM_RX_tvalid && BPM_TEST_AXI_STREAM_RX_tready;
  assign verdict = auroraFAstrobe && open_q;
  assign verdict_code = (ff_q || st_q != HEADER) ? 2'd3 : cf_q ? 2'd2 :
                        (k_q != expectedBPMcount) ? 2'd1 : 2'd0;
  // Session close/open bookkeeping, then parse the accepted word against the (possibly fresh) session state
  always_comb begin
    st_b = auroraFAstrobe ? HEADER : st_q;
    k_b = auroraFAstrobe ? 6'd0 : k_q;
    st_d = st_b;
    k_d = k_b;
    cf_d = cf_q && !auroraFAstrobe;
    ff_d = ff_q && !auroraFAstrobe;
    fa_d = fa_q;
    open_d = open_q || auroraFAstrobe;
    pv_d = verdict ? (k_q != 6'd0) : pv_q;
    pfa_d = verdict ? fa_q : pfa_q;
    strobe_d = verdict;
    code_d = verdict ? verdict_code : code_q;
    spc_d = verdict ? k_q : spc_q;
    lfa_d = verdict ? fa_q : lfa_q;
    err_d = (verdict && verdict_code != 2'd0 && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    if (acc && open_d) begin
      case (st_b)
        HEADER: begin
          cf_d = cf_d || w[31:16] != 16'hA5BE || !w[15] || {1'b0, w[4:0]} != k_b;
          ff_d = ff_d || tl;
          st_d = tl ? HEADER : X;
        end
        X: begin
          cf_d = cf_d || w[31:16] != 16'hCAFE || w[15:0] != {10'd0, k_b};
          ff_d = ff_d || tl;
          st_d = tl ? HEADER : Y;
        end
        Y: begin
          cf_d = cf_d || w[31:16] != 16'hBEEF || w[15:0] != {10'd0, k_b};
          ff_d = ff_d || tl;
          st_d = tl ? HEADER : SUM;
        end
        SUM: begin
          cf_d = cf_d || w[31] || w[15:0] != {10'd0, k_b} ||
                 ((k_b == 6'd0) ? (pv_d && w_fa != pfa_d + 15'd1) : (w_fa != fa_q));
          fa_d = (k_b == 6'd0) ? w_fa : fa_q;
          ff_d = ff_d || !tl;
          k_d = (tl && k_b != 6'd63) ? k_b + 6'd1 : k_b;
          st_d = tl ? HEADER : DISCARD;
        end
        default: st_d = tl ? HEADER : DISCARD;
      endcase
    end
  end
  // State and registered outputs
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      st_q <= HEADER;
      k_q <= '0;
      cf_q <= 1'b0;
      ff_q <= 1'b0;
      open_q <= 1'b0;
      fa_q <= '0;
      pv_q <= 1'b0;
      pfa_q <= '0;
      strobe_q <= 1'b0;
      code_q <= '0;
      spc_q <= '0;
      err_q <= '0;
      lfa_q <= '0;
    end else begin
      st_q <= st_d;
      k_q <= k_d;
      cf_q <= cf_d;
      ff_q <= ff_d;
      open_q <= open_d;
      fa_q <= fa_d;
      pv_q <= pv_d;
      pfa_q <= pfa_d;
      strobe_q <= strobe_d;
      code_q <= code_d;
      spc_q <= spc_d;
      err_q <= err_d;
      lfa_q <= lfa_d;
    end
  end
  assign TESTstatusStrobe = strobe_q;
  assign TESTstatusCode = code_q;
  assign sessionPacketCount = spc_q;
  assign errorCount = err_q;
  assign lastFAcycle = lfa_q;
endmodule
